// File: rtl/acc_operand_stage_pkg.sv
// Shared CPU definitions: ALU opcode set and operand-stage FSM encodings,
// also imported by the ALU and the control unit.
package acc_operand_stage_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_MPY    = 3'b010,
        OP_AND    = 3'b011,
        OP_OR     = 3'b100,
        OP_NOT    = 3'b101,
        OP_SHIFTR = 3'b110,
        OP_SHIFTL = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_WB   = 3'd2,
        ST_WBH  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Only multiply produces a high half that needs a second writeback cycle.
    function automatic logic is_mpy(input op_e op);
        return (op == OP_MPY);
    endfunction

endpackage

// File: rtl/acc_operand_stage.sv
// Accumulator/operand staging for the ALU: holds ACC, Q, OP and ACCH and
// sequences EXEC -> WB (-> WBH) -> DONE around each ALU operation.
module acc_operand_stage
    import acc_operand_stage_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_mbr_data,
    input  logic              i_load_acc,
    input  logic              i_start,
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_br,
    input  logic [DATA_W-1:0] i_mr,
    output logic [DATA_W-1:0] o_acc_alu_p,
    output logic [DATA_W-1:0] o_acc_alu_q,
    output logic [OP_W-1:0]   o_alu_op,
    output logic              o_alu_en,
    output logic              o_c9,
    output logic              o_c10,
    output logic [DATA_W-1:0] o_acc,
    output logic [DATA_W-1:0] o_acch,
    output logic              o_busy,
    output logic              o_done
);

    state_e            state_r;
    op_e               op_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] q_r;
    logic [DATA_W-1:0] acch_r;
    logic              alu_en_r;
    logic              c9_r;
    logic              c10_r;
    logic              busy_r;
    logic              done_r;

    // Control FSM and datapath registers; strobes are flops set one edge ahead
    // of the state they belong to, so no input reaches an output combinationally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_ADD;
            acc_r    <= 16'h0000;
            q_r      <= 16'h0000;
            acch_r   <= 16'h0000;
            alu_en_r <= 1'b0;
            c9_r     <= 1'b0;
            c10_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        q_r      <= i_mbr_data;
                        op_r     <= op_e'(i_op);
                        state_r  <= ST_EXEC;
                        alu_en_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else if (i_load_acc) begin
                        acc_r    <= i_mbr_data;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    alu_en_r <= 1'b0;
                    c9_r     <= 1'b1;
                    state_r  <= ST_WB;
                end
                ST_WB: begin
                    c9_r  <= 1'b0;
                    acc_r <= i_br;
                    if (is_mpy(op_r)) begin
                        c10_r   <= 1'b1;
                        state_r <= ST_WBH;
                    end else begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_WBH: begin
                    c10_r   <= 1'b0;
                    acch_r  <= i_mr;
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                    // A start seen on DONE's closing edge chains straight into EXEC.
                    if (i_start) begin
                        q_r      <= i_mbr_data;
                        op_r     <= op_e'(i_op);
                        state_r  <= ST_EXEC;
                        alu_en_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    alu_en_r <= 1'b0;
                    c9_r     <= 1'b0;
                    c10_r    <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_acc_alu_p = acc_r;
    assign o_acc_alu_q = q_r;
    assign o_alu_op    = op_r;
    assign o_alu_en    = alu_en_r;
    assign o_c9        = c9_r;
    assign o_c10       = c10_r;
    assign o_acc       = acc_r;
    assign o_acch      = acch_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;

endmodule
